// File: rtl/wb_master_bridge_pkg.sv
// Shared types, field layout and defaults for the request/response to Wishbone bridge.
package wb_master_bridge_pkg;

    localparam int REQ_W        = 69;
    localparam int RESP_W       = 33;
    localparam int REQ_WE_BIT   = 68;
    localparam int REQ_SEL_LSB  = 64;
    localparam int REQ_ADR_LSB  = 32;
    localparam int REQ_DAT_LSB  = 0;
    localparam int RESP_ERR_BIT = 32;
    localparam int SEL_W        = 4;
    localparam int ADR_W        = 32;
    localparam int DAT_W        = 32;
    localparam int CTR_W        = 16;

    localparam int unsigned TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Field order matches the bit positions above: we is the MSB.
    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } req_t;

    typedef struct packed {
        logic             err;
        logic [DAT_W-1:0] dat;
    } resp_t;

endpackage

// File: rtl/wb_master_bridge_if.sv
// Request/response handshake plus Wishbone classic master signals.
interface wb_master_bridge_if;
    import wb_master_bridge_pkg::*;

    logic [REQ_W-1:0]  req_msg;
    logic              req_val;
    logic              req_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              resp_val;
    logic              resp_rdy;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [ADR_W-1:0]  wbm_adr_o;
    logic [DAT_W-1:0]  wbm_dat_o;
    logic              wbm_ack_i;
    logic              wbm_err_i;
    logic [DAT_W-1:0]  wbm_dat_i;

    modport master (
        input  req_msg, req_val, resp_rdy, wbm_ack_i, wbm_err_i, wbm_dat_i,
        output req_rdy, resp_msg, resp_val,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output req_msg, req_val, resp_rdy, wbm_ack_i, wbm_err_i, wbm_dat_i,
        input  req_rdy, resp_msg, resp_val,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus wait counter; expired flags the last cycle allowed before abandoning a transfer.
module wb_timeout_ctr
    import wb_master_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(LIMIT - 1);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding request/response to Wishbone classic master bridge.
// state   | meaning
// IDLE    | req_rdy high, waiting for a request
// BUS     | cyc/stb asserted, waiting for ack, err or timeout
// RESP    | resp_val high until the consumer takes it
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_master_bridge_if.master bus
);

    state_t           state;
    req_t             req;
    resp_t            resp_r;
    logic             req_rdy_r;
    logic             resp_val_r;
    logic             cyc_r;
    logic             stb_r;
    logic             we_r;
    logic [SEL_W-1:0] sel_r;
    logic [ADR_W-1:0] adr_r;
    logic [DAT_W-1:0] dat_r;
    logic             expired;
    logic             ctr_clear;
    logic             ctr_en;

    assign req       = req_t'(bus.req_msg);
    assign ctr_clear = (state != ST_BUS);
    assign ctr_en    = (state == ST_BUS) && !bus.wbm_ack_i && !bus.wbm_err_i;

    wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            req_rdy_r  <= 1'b1;
            resp_val_r <= 1'b0;
            resp_r     <= '0;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= '0;
            adr_r      <= '0;
            dat_r      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_val) begin
                        state     <= ST_BUS;
                        req_rdy_r <= 1'b0;
                        cyc_r     <= 1'b1;
                        stb_r     <= 1'b1;
                        we_r      <= req.we;
                        sel_r     <= req.sel;
                        adr_r     <= req.adr;
                        dat_r     <= req.dat;
                    end
                end
                ST_BUS: begin
                    // A real termination always wins over the timeout in the same cycle.
                    if (bus.wbm_err_i || bus.wbm_ack_i || expired) begin
                        state      <= ST_RESP;
                        cyc_r      <= 1'b0;
                        stb_r      <= 1'b0;
                        we_r       <= 1'b0;
                        resp_val_r <= 1'b1;
                        if (bus.wbm_err_i) begin
                            resp_r <= '{err: 1'b1, dat: '0};
                        end else if (bus.wbm_ack_i) begin
                            resp_r <= '{err: 1'b0, dat: (we_r ? '0 : bus.wbm_dat_i)};
                        end else begin
                            resp_r <= '{err: 1'b1, dat: '0};
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.resp_rdy) begin
                        state      <= ST_IDLE;
                        resp_val_r <= 1'b0;
                        req_rdy_r  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_rdy_r  <= 1'b1;
                    resp_val_r <= 1'b0;
                    cyc_r      <= 1'b0;
                    stb_r      <= 1'b0;
                    we_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy   = req_rdy_r;
    assign bus.resp_val  = resp_val_r;
    assign bus.resp_msg  = resp_r;
    assign bus.wbm_cyc_o = cyc_r;
    assign bus.wbm_stb_o = stb_r;
    assign bus.wbm_we_o  = we_r;
    assign bus.wbm_sel_o = sel_r;
    assign bus.wbm_adr_o = adr_r;
    assign bus.wbm_dat_o = dat_r;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a transaction-level reference model.
module tb_wb_master_bridge;
    import wb_master_bridge_pkg::*;

    localparam int TMO    = 4;
    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_BOTH = 3;

    logic clk = 1'b0;
    logic rst_n;

    wb_master_bridge_if bus();

    wb_master_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave behaviour knobs and stray-termination injection
    int          s_kind  = K_NONE;
    int          s_delay = 0;
    int          s_cnt   = 0;
    logic [31:0] s_dat   = '0;
    logic        s_ack   = 1'b0;
    logic        s_err   = 1'b0;
    logic        st_ack  = 1'b0;
    logic        st_err  = 1'b0;

    assign bus.wbm_ack_i = s_ack | st_ack;
    assign bus.wbm_err_i = s_err | st_err;
    assign bus.wbm_dat_i = s_dat;

    // reference model: one outstanding transaction, counted in bus cycles
    logic        m_bus  = 1'b0;
    logic        m_resp = 1'b0;
    int          m_n    = 0;
    req_t        m_req  = '0;
    logic [32:0] m_rmsg = '0;
    logic        m_term;
    logic [32:0] m_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bus  = 1'b0;
            m_resp = 1'b0;
            m_n    = 0;
            m_req  = '0;
            m_rmsg = '0;
        end else if (m_bus) begin
            m_term = 1'b1;
            m_r    = '0;
            if (bus.wbm_err_i)               m_r = {1'b1, 32'h0};
            else if (bus.wbm_ack_i)          m_r = {1'b0, m_req.we ? 32'h0 : bus.wbm_dat_i};
            else if (m_n == TMO)             m_r = {1'b1, 32'h0};
            else begin
                m_term = 1'b0;
                m_n    = m_n + 1;
            end
            if (m_term) begin
                m_bus  = 1'b0;
                m_resp = 1'b1;
                m_rmsg = m_r;
            end
        end else if (m_resp) begin
            if (bus.resp_rdy) m_resp = 1'b0;
        end else if (bus.req_val) begin
            m_req = req_t'(bus.req_msg);
            m_bus = 1'b1;
            m_n   = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("req_rdy",  64'(bus.req_rdy),   64'(!m_bus && !m_resp));
            check("cyc",      64'(bus.wbm_cyc_o), 64'(m_bus));
            check("stb",      64'(bus.wbm_stb_o), 64'(m_bus));
            check("we",       64'(bus.wbm_we_o),  64'(m_bus && m_req.we));
            check("sel",      64'(bus.wbm_sel_o), 64'(m_req.sel));
            check("adr",      64'(bus.wbm_adr_o), 64'(m_req.adr));
            check("dat",      64'(bus.wbm_dat_o), 64'(m_req.dat));
            check("resp_val", 64'(bus.resp_val),  64'(m_resp));
            check("resp_msg", 64'(bus.resp_msg),  64'(m_rmsg));
        end
    end

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n || !(bus.wbm_cyc_o && bus.wbm_stb_o)) begin
                s_ack = 1'b0;
                s_err = 1'b0;
                s_cnt = 0;
            end else begin
                if (s_kind != K_NONE && s_cnt == s_delay) begin
                    s_ack = (s_kind == K_ACK) || (s_kind == K_BOTH);
                    s_err = (s_kind == K_ERR) || (s_kind == K_BOTH);
                end else begin
                    s_ack = 1'b0;
                    s_err = 1'b0;
                end
                s_cnt++;
            end
        end
    end

    task automatic cfg(input int kind, input int delay, input logic [31:0] rdat);
        s_kind  = kind;
        s_delay = delay;
        s_dat   = rdat;
    endtask

    // Returns one cycle after acceptance, i.e. in the first bus cycle.
    task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
        int k = 0;
        while (!bus.req_rdy && k < 50) begin
            tick();
            k++;
        end
        if (!bus.req_rdy) check("send_wait_rdy", 64'(bus.req_rdy), 64'd1);
        bus.req_msg = {we, sel, adr, dat};
        bus.req_val = 1'b1;
        tick();
        bus.req_val = 1'b0;
    endtask

    task automatic wait_resp(input logic [31:0] wdat, output int cyc_n, output int we_n);
        int k = 0;
        cyc_n = 0;
        we_n  = 0;
        while (!bus.resp_val && k < 50) begin
            if (bus.wbm_cyc_o) cyc_n++;
            if (bus.wbm_we_o && bus.wbm_dat_o == wdat) we_n++;
            tick();
            k++;
        end
        if (!bus.resp_val) check("wait_resp_timeout", 64'(bus.resp_val), 64'd1);
    endtask

    int cyc_n;
    int we_n;

    initial begin
        bus.req_val  = 1'b0;
        bus.req_msg  = '0;
        bus.resp_rdy = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_req_rdy",  64'(bus.req_rdy),   64'd1);
        check("rst_cyc",      64'(bus.wbm_cyc_o), 64'd0);
        check("rst_resp_val", 64'(bus.resp_val),  64'd0);
        check("rst_resp_msg", 64'(bus.resp_msg),  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // read, ack in first bus cycle
        cfg(K_ACK, 0, 32'hDEADBEEF);
        send(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        check("rd_adr_n1", 64'(bus.wbm_adr_o), 64'h3000_0008);
        check("rd_cyc_n1", 64'(bus.wbm_cyc_o), 64'd1);
        tick();
        check("rd_resp_val_n2", 64'(bus.resp_val), 64'd1);
        check("rd_resp_msg_n2", 64'(bus.resp_msg), 64'({1'b0, 32'hDEADBEEF}));
        tick();
        check("rd_req_rdy_n3", 64'(bus.req_rdy), 64'd1);

        // write, ack after 3 wait cycles (lands on the timeout cycle)
        cfg(K_ACK, 3, 32'hFFFF_FFFF);
        send(1'b1, 4'h3, 32'h3000_0000, 32'h1234_5678);
        wait_resp(32'h1234_5678, cyc_n, we_n);
        check("wr_we_cycles",  64'(we_n), 64'd4);
        check("wr_cyc_cycles", 64'(cyc_n), 64'd4);
        check("wr_resp_msg",   64'(bus.resp_msg), 64'd0);
        tick();

        // timeout with silent slave
        cfg(K_NONE, 0, 32'h0);
        send(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        wait_resp(32'h0, cyc_n, we_n);
        check("tmo_cyc_cycles", 64'(cyc_n), 64'd4);
        check("tmo_resp_msg",   64'(bus.resp_msg), 64'({1'b1, 32'h0}));
        tick();

        // response backpressure with stray terminations during RESP
        bus.resp_rdy = 1'b0;
        cfg(K_ACK, 1, 32'hCAFE_F00D);
        send(1'b0, 4'hC, 32'h3000_0004, 32'h0);
        wait_resp(32'h0, cyc_n, we_n);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_msg", 64'(bus.resp_msg), 64'({1'b0, 32'hCAFE_F00D}));
            check("bp_req_rdy",  64'(bus.req_rdy),  64'd0);
            check("bp_cyc",      64'(bus.wbm_cyc_o), 64'd0);
            st_ack = 1'b1;
            st_err = 1'b1;
            tick();
        end
        st_ack = 1'b0;
        st_err = 1'b0;
        bus.resp_rdy = 1'b1;
        tick();
        check("bp_idle_req_rdy", 64'(bus.req_rdy), 64'd1);

        // simultaneous ack and err
        cfg(K_BOTH, 0, 32'h5555_AAAA);
        send(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        wait_resp(32'h0, cyc_n, we_n);
        check("both_resp_msg", 64'(bus.resp_msg), 64'({1'b1, 32'h0}));
        tick();

        // stray ack while idle
        st_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_req_rdy",  64'(bus.req_rdy),  64'd1);
            check("stray_resp_val", 64'(bus.resp_val), 64'd0);
        end
        st_ack = 1'b0;

        // reset during the second bus cycle
        cfg(K_NONE, 0, 32'h0);
        send(1'b1, 4'hF, 32'h3000_0030, 32'hA5A5_A5A5);
        tick();
        check("rst_mid_cyc_before", 64'(bus.wbm_cyc_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", 64'(bus.wbm_cyc_o), 64'd0);
        check("rst_mid_stb", 64'(bus.wbm_stb_o), 64'd0);
        check("rst_mid_adr", 64'(bus.wbm_adr_o), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rel_req_rdy", 64'(bus.req_rdy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rel_no_resp", 64'(bus.resp_val), 64'd0);
        end

        // normal read after reset recovery
        cfg(K_ACK, 2, 32'h0BAD_F00D);
        send(1'b0, 4'h1, 32'h3000_0040, 32'h0);
        wait_resp(32'h0, cyc_n, we_n);
        check("post_rd_cyc_cycles", 64'(cyc_n), 64'd3);
        check("post_rd_resp_msg",   64'(bus.resp_msg), 64'({1'b0, 32'h0BAD_F00D}));
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum bus cycles to wait for ack/err before a transaction is abandoned (legal range 2..65535).
REQ-002 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-003 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-004 req_msg  in  69  request {we[68], sel[67:64], adr[63:32], dat[31:0]}.
REQ-005 req_val  in  1  request valid.
REQ-006 req_rdy  out  1  bridge can accept a request.
REQ-007 resp_msg  out  33  response {err[32], dat[31:0]}.
REQ-008 resp_val  out  1  response valid.
REQ-009 resp_rdy  in  1  consumer accepts response.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-011 wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32  Wishbone byte select, address, write data.
REQ-012 wbm_ack_i, wbm_err_i  in  1 each; wbm_dat_i  in  32  slave termination and read data.

Function
REQ-013 The FSM SHALL have states IDLE, BUS, RESP; req_rdy SHALL be 1 only in IDLE.
REQ-014 IDLE: when req_val=1, the bridge SHALL latch req_msg into registers and enter BUS on the next edge.
REQ-015 BUS: wbm_cyc_o and wbm_stb_o SHALL be 1 and wbm_we_o/sel/adr/dat SHALL drive the latched fields, all from registers (no combinational path from req_* to wbm_*).
REQ-016 BUS: on wbm_ack_i=1 the bridge SHALL capture resp dat = wbm_dat_i for reads, 0 for writes, err=0, and enter RESP; cyc/stb SHALL be 0 in the following cycle.
REQ-017 BUS: on wbm_err_i=1 the bridge SHALL enter RESP with err=1, dat=0; if ack and err are both 1, err SHALL take precedence.
REQ-018 BUS: a 16-bit wait counter, cleared on entry to BUS, SHALL increment each BUS cycle without ack/err; on the cycle where it equals TIMEOUT_CYCLES-1 with no ack/err, the bridge SHALL enter RESP with err=1, dat=0.
REQ-019 A termination arriving in the same cycle as the timeout condition SHALL take priority over the timeout.
REQ-020 RESP: resp_val SHALL be 1 and resp_msg stable; on resp_rdy=1 the bridge SHALL return to IDLE.
REQ-021 wbm_ack_i/wbm_err_i in IDLE or RESP SHALL be ignored (no state or data change).
REQ-022 Latency: request accepted in cycle N -> cyc/stb high in cycle N+1 -> with ack in N+1, resp_val high in N+2; with resp_rdy held at 1, req_rdy is high again in N+3.
REQ-023 Outside BUS, wbm_cyc_o, wbm_stb_o and wbm_we_o SHALL be 0; adr/sel/dat hold their last values.
REQ-024 Outside RESP, resp_val SHALL be 0; resp_msg holds its last value.

Reset
REQ-025 Asserting wb_rst_ni low SHALL immediately force IDLE, clear wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_val and the wait counter, and zero wbm_sel_o, wbm_adr_o, wbm_dat_o and resp_msg.
REQ-026 Reset mid-transaction (BUS or RESP) SHALL abandon that transaction with no response; req_rdy SHALL be 1 in the first cycle after release.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the request/response field widths and bit positions, and the TIMEOUT_CYCLES default.
REQ-028 The wait counter SHALL be a sub-module named wb_timeout_ctr (clear, enable, expired output); all other logic lives in wb_master_bridge.

Verification
REQ-029 Read: req {we=0, sel=F, adr=0x30000008}; slave acks in the first BUS cycle with 0xDEADBEEF -> wbm_adr_o=0x30000008 in cycle N+1; resp {err=0, dat=0xDEADBEEF} in N+2.
REQ-030 Write: req {we=1, sel=3, adr=0x30000000, dat=0x12345678}; ack after 3 wait cycles -> wbm_we_o=1 and wbm_dat_o=0x12345678 for 4 cycles; resp {0, 0x00000000}.
REQ-031 Timeout with TIMEOUT_CYCLES=4 and no slave reply -> cyc high for exactly 4 cycles; resp {err=1, dat=0}.
REQ-032 Backpressure: resp_rdy low for 5 cycles after resp_val -> resp_msg stable, req_rdy=0 throughout, cyc=0; IDLE after resp_rdy rises.
REQ-033 Simultaneous ack+err -> resp err=1, dat=0; a stray ack in IDLE -> no response, no state change.
REQ-034 Reset asserted in the second BUS cycle -> cyc/stb low in the same cycle, no response emitted, req_rdy=1 after release.
